// File: rtl/ysyx_23060203_idu.sv
// Instruction decode stage: one pipeline register that captures the fetched
// word and its decoded control fields, with flush and valid/ready handshakes.
module ysyx_23060203_idu #(
    parameter int RVE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [3:0]  out_type,
    output logic [2:0]  out_funct3,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic        out_rs1_en,
    output logic        out_rs2_en,
    output logic        out_rd_en,
    output logic [31:0] out_imm,
    output logic        out_illegal,
    output logic        out_fencei
);

    typedef enum logic [3:0] {
        T_OP     = 4'd0,
        T_OPIMM  = 4'd1,
        T_LOAD   = 4'd2,
        T_STORE  = 4'd3,
        T_BRANCH = 4'd4,
        T_JAL    = 4'd5,
        T_JALR   = 4'd6,
        T_LUI    = 4'd7,
        T_AUIPC  = 4'd8,
        T_SYSTEM = 4'd9,
        T_FENCE  = 4'd10,
        T_OTHER  = 4'd15
    } inst_type_e;

    logic        valid_r;
    logic [31:0] pc_r;
    logic [31:0] inst_r;
    logic [3:0]  type_r;
    logic [31:0] imm_r;
    logic        rs1_en_r;
    logic        rs2_en_r;
    logic        rd_en_r;
    logic        illegal_r;
    logic        fencei_r;

    inst_type_e  dec_type;
    logic [31:0] dec_imm;
    logic        dec_rs1_en;
    logic        dec_rs2_en;
    logic        dec_rd_wr;
    logic        dec_rd_en;
    logic        dec_bad_f3;
    logic        dec_big_reg;
    logic        dec_illegal;
    logic        dec_fencei;
    logic [2:0]  f3;
    logic        transfer;

    assign f3       = in_inst[14:12];
    assign in_ready = ~valid_r | out_ready;
    assign transfer = in_valid & in_ready;

    // Decode the incoming word so its fields are registered on the accepting edge.
    always_comb begin
        dec_type = T_OTHER;
        case (in_inst[6:0])
            7'b0110011: dec_type = T_OP;
            7'b0010011: dec_type = T_OPIMM;
            7'b0000011: dec_type = T_LOAD;
            7'b0100011: dec_type = T_STORE;
            7'b1100011: dec_type = T_BRANCH;
            7'b1101111: dec_type = T_JAL;
            7'b1100111: dec_type = T_JALR;
            7'b0110111: dec_type = T_LUI;
            7'b0010111: dec_type = T_AUIPC;
            7'b1110011: dec_type = T_SYSTEM;
            7'b0001111: dec_type = T_FENCE;
            default:    dec_type = T_OTHER;
        endcase

        dec_imm = 32'd0;
        case (dec_type)
            T_OPIMM, T_LOAD, T_JALR, T_SYSTEM:
                dec_imm = {{20{in_inst[31]}}, in_inst[31:20]};
            T_STORE:
                dec_imm = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            T_BRANCH:
                dec_imm = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
            T_LUI, T_AUIPC:
                dec_imm = {in_inst[31:12], 12'd0};
            T_JAL:
                dec_imm = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
            default:
                dec_imm = 32'd0;
        endcase

        dec_rs1_en = (dec_type == T_OP) || (dec_type == T_OPIMM) || (dec_type == T_LOAD) ||
                     (dec_type == T_STORE) || (dec_type == T_BRANCH) || (dec_type == T_JALR) ||
                     ((dec_type == T_SYSTEM) && !f3[2]);
        dec_rs2_en = (dec_type == T_OP) || (dec_type == T_STORE) || (dec_type == T_BRANCH);
        dec_rd_wr  = (dec_type == T_OP) || (dec_type == T_OPIMM) || (dec_type == T_LOAD) ||
                     (dec_type == T_JAL) || (dec_type == T_JALR) || (dec_type == T_LUI) ||
                     (dec_type == T_AUIPC) || ((dec_type == T_SYSTEM) && (f3 != 3'd0));
        dec_rd_en  = dec_rd_wr && (in_inst[11:7] != 5'd0);

        dec_bad_f3 = ((dec_type == T_LOAD) && ((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7))) ||
                     ((dec_type == T_STORE) && (f3 >= 3'd3)) ||
                     ((dec_type == T_BRANCH) && ((f3 == 3'd2) || (f3 == 3'd3))) ||
                     ((dec_type == T_JALR) && (f3 != 3'd0));
        // Write intent counts even for rd == 0, so x16..x31 as a discarded rd still traps.
        dec_big_reg = (RVE != 0) && ((dec_rs1_en && in_inst[19]) ||
                                     (dec_rs2_en && in_inst[24]) ||
                                     (dec_rd_wr && in_inst[11]));
        dec_illegal = (dec_type == T_OTHER) || (in_inst[1:0] != 2'b11) || dec_big_reg || dec_bad_f3;
        dec_fencei  = (dec_type == T_FENCE) && (f3 == 3'd1);
    end

    // Pipeline register; flush wins over a simultaneous transfer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_r   <= 1'b0;
            pc_r      <= 32'd0;
            inst_r    <= 32'd0;
            type_r    <= 4'd0;
            imm_r     <= 32'd0;
            rs1_en_r  <= 1'b0;
            rs2_en_r  <= 1'b0;
            rd_en_r   <= 1'b0;
            illegal_r <= 1'b0;
            fencei_r  <= 1'b0;
        end else begin
            valid_r <= ~flush & (transfer | (valid_r & ~out_ready));
            if (transfer && !flush) begin
                pc_r      <= in_pc;
                inst_r    <= in_inst;
                type_r    <= dec_type;
                imm_r     <= dec_imm;
                rs1_en_r  <= dec_rs1_en;
                rs2_en_r  <= dec_rs2_en;
                rd_en_r   <= dec_rd_en;
                illegal_r <= dec_illegal;
                fencei_r  <= dec_fencei;
            end
        end
    end

    assign out_valid   = valid_r & ~flush;
    assign out_pc      = pc_r;
    assign out_inst    = inst_r;
    assign out_type    = type_r;
    assign out_funct3  = inst_r[14:12];
    assign out_rs1     = inst_r[19:15];
    assign out_rs2     = inst_r[24:20];
    assign out_rd      = inst_r[11:7];
    assign out_rs1_en  = rs1_en_r;
    assign out_rs2_en  = rs2_en_r;
    assign out_rd_en   = rd_en_r;
    assign out_imm     = imm_r;
    assign out_illegal = illegal_r;
    assign out_fencei  = out_valid & out_ready & fencei_r;

endmodule
